// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions slow, asynchronous board inputs (DIP switches, push buttons)
// before they reach the SoC. Each channel goes through a multi-flop
// synchronizer and then a consecutive-cycle stability filter. A new value is
// accepted only after it has been seen for DebounceCycles cycles in a row.
//
// Ports:
//   clk_i      SoC clock
//   rst_ni     asynchronous active-low reset
//   async_i    raw pad inputs, asynchronous to clk_i
//   level_o    debounced level per channel
//   rise_o     one-cycle pulse when level_o goes 0->1
//   fall_o     one-cycle pulse when level_o goes 1->0
//   changed_o  sticky per-channel flag, set by any accepted edge
//   clear_i    per-channel clear of changed_o (a coincident set wins)
// -----------------------------------------------------------------------------
module input_debouncer #(
   parameter int                   NumInputs      = 8,
   parameter int                   SyncStages     = 2,
   parameter int                   DebounceCycles = 200000,
   parameter logic [NumInputs-1:0] ResetValue     = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NumInputs-1:0] async_i,
   output logic [NumInputs-1:0] level_o,
   output logic [NumInputs-1:0] rise_o,
   output logic [NumInputs-1:0] fall_o,
   output logic [NumInputs-1:0] changed_o,
   input  logic [NumInputs-1:0] clear_i
);

   localparam int                  CntWidth = $clog2(DebounceCycles + 1);
   localparam logic [CntWidth-1:0] CntLast  = CntWidth'(DebounceCycles - 1);
   localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

   // A synchronizer shallower than two flops, or a zero-length filter, would
   // not make sense; refuse to elaborate rather than build something unsafe.
   if (DebounceCycles < 1 || SyncStages < 2) begin : g_param_check
      $error("input_debouncer: DebounceCycles must be >= 1 and SyncStages >= 2");
   end

   logic [NumInputs-1:0] sync_q [SyncStages];
   logic [NumInputs-1:0] sync_out;
   logic [CntWidth-1:0]  cnt_q  [NumInputs];
   logic [NumInputs-1:0] level_q;
   logic [NumInputs-1:0] rise_q;
   logic [NumInputs-1:0] fall_q;
   logic [NumInputs-1:0] changed_q;

   // Plain flop chain into the clock domain; nothing may sit between the
   // stages so each flop gets a full cycle to resolve metastability.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SyncStages; s++) begin
            sync_q[s] <= ResetValue;
         end
      end else begin
         sync_q[0] <= async_i;
         for (int s = 1; s < SyncStages; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync_out = sync_q[SyncStages-1];

   // Stability filter. The counter tracks how many consecutive cycles the
   // synchronized input has disagreed with the accepted level. Any agreeing
   // cycle restarts it, so short glitches never reach level_o. On the last
   // disagreeing cycle the level flips and the matching edge pulse is raised
   // in the same cycle, so the pulse lines up with the new level_o. The
   // counter is cleared on acceptance and so can never run past CntLast.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= ResetValue;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < NumInputs; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < NumInputs; i++) begin
            if (sync_out[i] == level_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntLast) begin
               cnt_q[i]   <= '0;
               level_q[i] <= sync_out[i];
               rise_q[i]  <= sync_out[i];
               fall_q[i]  <= ~sync_out[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + CntOne;
            end
         end
      end
   end

   // Sticky change flag, registered from the edge pulses so it rises the
   // cycle after a pulse. A pulse arriving together with a clear keeps the
   // flag set so that an edge is never silently lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         changed_q <= '0;
      end else begin
         changed_q <= (changed_q & ~clear_i) | rise_q | fall_q;
      end
   end

   assign level_o   = level_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign changed_o = changed_q;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Self-checking bench for input_debouncer (4 channels, 2 sync stages,
// 4-cycle filter). Stimulus pushes hand-computed edge events (cycle, rise,
// fall, level) into a scoreboard queue; a monitor pops and compares whenever
// the DUT shows a rise or fall pulse. Level and changed flags are also
// checked directly at chosen points.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_input_debouncer;

   localparam int N = 4;

   typedef struct {
      int           cycle;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] level;
   } event_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] async_in;
   logic [N-1:0] clear;
   logic [N-1:0] level;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] changed;

   event_t exp_q[$];
   int     tests    = 0;
   int     failures = 0;
   int     cyc      = 0;

   input_debouncer #(
      .NumInputs      (N),
      .SyncStages     (2),
      .DebounceCycles (4),
      .ResetValue     (4'b0000)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .async_i   (async_in),
      .level_o   (level),
      .rise_o    (rise),
      .fall_o    (fall),
      .changed_o (changed),
      .clear_i   (clear)
   );

   // Free-running clock and a count of rising edges used to time events.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] async_val,
                                input logic [N-1:0] clear_val);
      async_in = async_val;
      clear    = clear_val;
   endtask

   task automatic expectPulse(input int cycle, input logic [N-1:0] r,
                              input logic [N-1:0] f, input logic [N-1:0] l);
      event_t e;
      e.cycle = cycle;
      e.rise  = r;
      e.fall  = f;
      e.level = l;
      exp_q.push_back(e);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse seen on the DUT must match the oldest expected
   // event; a pulse with nothing expected is itself a failure.
   always @(negedge clk) begin
      event_t e;
      if (rst_n === 1'b1 && (rise !== '0 || fall !== '0)) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse", {24'd0, rise, fall}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("pulse_cycle", cyc, e.cycle);
            checkOutput("pulse_rise", {28'd0, rise}, {28'd0, e.rise});
            checkOutput("pulse_fall", {28'd0, fall}, {28'd0, e.fall});
            checkOutput("pulse_level", {28'd0, level}, {28'd0, e.level});
         end
      end
   end

   // Hard time bound so the run always ends.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: run exceeded time bound");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      rst_n = 1'b0;
      applyStimulus(4'b0000, 4'b0000);
      waitCycles(3);
      checkOutput("reset_level", {28'd0, level}, 32'd0);
      checkOutput("reset_rise", {28'd0, rise}, 32'd0);
      checkOutput("reset_fall", {28'd0, fall}, 32'd0);
      checkOutput("reset_changed", {28'd0, changed}, 32'd0);
      rst_n = 1'b1;

      // Idle with inputs low: nothing may move.
      waitCycles(20);
      checkOutput("idle_level", {28'd0, level}, 32'd0);
      checkOutput("idle_changed", {28'd0, changed}, 32'd0);

      // Clean rise on channel 0.
      applyStimulus(4'b0001, 4'b0000);
      t = cyc;
      expectPulse(t + 6, 4'b0001, 4'b0000, 4'b0001);
      waitCycles(5);
      checkOutput("rise_not_early", {28'd0, level}, 32'h0);
      waitCycles(1);
      checkOutput("rise_level", {28'd0, level}, 32'h1);
      checkOutput("rise_changed_not_yet", {28'd0, changed}, 32'h0);
      waitCycles(1);
      checkOutput("rise_changed_set", {28'd0, changed}, 32'h1);
      waitCycles(4);
      checkOutput("rise_changed_held", {28'd0, changed}, 32'h1);

      // Glitch of 3 cycles on channel 1 is rejected.
      applyStimulus(4'b0011, 4'b0000);
      waitCycles(3);
      applyStimulus(4'b0001, 4'b0000);
      waitCycles(10);
      checkOutput("glitch_level", {28'd0, level}, 32'h1);
      checkOutput("glitch_changed", {28'd0, changed}, 32'h1);

      // A 4-cycle pulse is accepted, and its falling edge too.
      applyStimulus(4'b0011, 4'b0000);
      t = cyc;
      expectPulse(t + 6, 4'b0010, 4'b0000, 4'b0011);
      expectPulse(t + 10, 4'b0000, 4'b0010, 4'b0001);
      waitCycles(4);
      applyStimulus(4'b0001, 4'b0000);
      waitCycles(12);
      checkOutput("pulse4_level", {28'd0, level}, 32'h1);
      checkOutput("pulse4_changed", {28'd0, changed}, 32'h3);

      // Bouncing input on channel 2 settles high: one rise only.
      applyStimulus(4'b0101, 4'b0000);
      waitCycles(2);
      applyStimulus(4'b0001, 4'b0000);
      waitCycles(2);
      applyStimulus(4'b0101, 4'b0000);
      waitCycles(2);
      applyStimulus(4'b0001, 4'b0000);
      waitCycles(2);
      applyStimulus(4'b0101, 4'b0000);
      t = cyc;
      expectPulse(t + 6, 4'b0100, 4'b0000, 4'b0101);
      waitCycles(5);
      checkOutput("bounce_not_early", {28'd0, level}, 32'h1);
      waitCycles(1);
      checkOutput("bounce_level", {28'd0, level}, 32'h5);
      waitCycles(4);
      checkOutput("bounce_changed", {28'd0, changed}, 32'h7);

      // Drop channel 0, then raise channels 0 and 3 together.
      applyStimulus(4'b0100, 4'b0000);
      t = cyc;
      expectPulse(t + 6, 4'b0000, 4'b0001, 4'b0100);
      waitCycles(10);
      applyStimulus(4'b1101, 4'b0000);
      t = cyc;
      expectPulse(t + 6, 4'b1001, 4'b0000, 4'b1101);
      waitCycles(8);
      checkOutput("simul_level", {28'd0, level}, 32'hd);
      checkOutput("simul_changed", {28'd0, changed}, 32'hf);

      // Clear on channel 0 coinciding with a new fall event: set wins.
      applyStimulus(4'b1100, 4'b0000);
      t = cyc;
      expectPulse(t + 6, 4'b0000, 4'b0001, 4'b1100);
      waitCycles(6);
      applyStimulus(4'b1100, 4'b0001);
      waitCycles(1);
      applyStimulus(4'b1100, 4'b0000);
      checkOutput("set_wins_changed", {28'd0, changed}, 32'hf);

      // Plain clears on channels 3 and then 0.
      applyStimulus(4'b1100, 4'b1000);
      waitCycles(1);
      applyStimulus(4'b1100, 4'b0000);
      checkOutput("clear3_changed", {28'd0, changed}, 32'h7);
      applyStimulus(4'b1100, 4'b0001);
      waitCycles(1);
      applyStimulus(4'b1100, 4'b0000);
      checkOutput("clear0_changed", {28'd0, changed}, 32'h6);

      // Reset in the middle of filtering a rise on channel 0. Channels 2 and
      // 3 are still driven high, so after release all three rise together.
      applyStimulus(4'b1101, 4'b0000);
      waitCycles(3);
      rst_n = 1'b0;
      waitCycles(1);
      checkOutput("midreset_level", {28'd0, level}, 32'h0);
      checkOutput("midreset_rise", {28'd0, rise}, 32'h0);
      checkOutput("midreset_changed", {28'd0, changed}, 32'h0);
      waitCycles(1);
      rst_n = 1'b1;
      t = cyc;
      expectPulse(t + 6, 4'b1101, 4'b0000, 4'b1101);
      waitCycles(5);
      checkOutput("postreset_not_early", {28'd0, level}, 32'h0);
      waitCycles(1);
      checkOutput("postreset_level", {28'd0, level}, 32'hd);
      waitCycles(1);
      checkOutput("postreset_changed", {28'd0, changed}, 32'hd);

      waitCycles(5);
      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
